// File: rtl/div_seq_if.sv
// div_seq_if
//  Start/done handshake and operand/result bundle for the sequential divider.
//  master : requester side (drives start, num1, num2; receives status/results)
//  slave  : divider side (receives request; drives busy, done, div_by_zero,
//           quotient, remainder)
//  Signals:
//   start        request pulse/level, sampled by the divider only when idle
//   num1, num2   dividend and divisor, BITS wide, unsigned
//   busy         high while the divider is iterating
//   done         one-cycle pulse marking valid results
//   div_by_zero  set with done when the divisor was zero
//   quotient     result quotient, BITS wide
//   remainder    result remainder, BITS wide
interface div_seq_if #(
  parameter int BITS = 4
);
  logic            start;
  logic [BITS-1:0] num1;
  logic [BITS-1:0] num2;
  logic            busy;
  logic            done;
  logic            div_by_zero;
  logic [BITS-1:0] quotient;
  logic [BITS-1:0] remainder;

  modport master (
    output start, num1, num2,
    input  busy, done, div_by_zero, quotient, remainder
  );

  modport slave (
    input  start, num1, num2,
    output busy, done, div_by_zero, quotient, remainder
  );
endinterface

// File: rtl/div_seq_ctrl.sv
// div_seq_ctrl
//  Sequential restoring divider: one trial subtraction through a single shared
//  BITS+1 wide subtractor per clock, producing one quotient bit per cycle.
//  Unsigned quotient/remainder are returned through the start/done handshake.
//  Ports:
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset (aborts any operation in flight)
//   bus    div_seq_if.slave: start, num1, num2 in; busy, done, div_by_zero,
//          quotient, remainder out (all outputs registered)
module div_seq_ctrl #(
  parameter int BITS = 4
) (
  input logic      clk,
  input logic      rst_n,
  div_seq_if.slave bus
);

  localparam int CNT_W = $clog2(BITS);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t          state_r;
  logic [BITS-1:0] div_r;     // latched divisor D
  logic [BITS-1:0] quo_r;     // shifts dividend out, quotient bits in
  logic [BITS:0]   rem_r;     // partial remainder R, one bit wider than operands
  logic [CNT_W-1:0] cnt_r;    // iterations remaining minus one
  logic            dz_r;      // divide-by-zero flag for the pending result

  logic [BITS:0]   trial_s;
  logic [BITS:0]   diff_s;
  logic            carry_s;
  logic [BITS:0]   rem_next_s;
  logic [BITS-1:0] quo_next_s;
  logic            rem_msb_unused_s;

  // After a restoring step R < D, so the top bit of R never feeds back.
  assign rem_msb_unused_s = rem_r[BITS];

  // Shared subtractor: T + ~D + 1; carry-out high means T >= D (restore otherwise).
  always_comb begin
    trial_s    = {rem_r[BITS-1:0], quo_r[BITS-1]};
    {carry_s, diff_s} = {1'b0, trial_s} + {1'b0, ~{1'b0, div_r}} + {{(BITS+1){1'b0}}, 1'b1};
    rem_next_s = trial_s;
    quo_next_s = {quo_r[BITS-2:0], 1'b0};
    if (carry_s) begin
      rem_next_s = diff_s;
      quo_next_s = {quo_r[BITS-2:0], 1'b1};
    end else begin
      rem_next_s = trial_s;
      quo_next_s = {quo_r[BITS-2:0], 1'b0};
    end
  end

  // Control FSM with datapath registers and registered handshake outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r         <= IDLE;
      div_r           <= {BITS{1'b0}};
      quo_r           <= {BITS{1'b0}};
      rem_r           <= {(BITS+1){1'b0}};
      cnt_r           <= {CNT_W{1'b0}};
      dz_r            <= 1'b0;
      bus.busy        <= 1'b0;
      bus.done        <= 1'b0;
      bus.div_by_zero <= 1'b0;
      bus.quotient    <= {BITS{1'b0}};
      bus.remainder   <= {BITS{1'b0}};
    end else begin
      bus.done <= 1'b0;
      case (state_r)
        IDLE: begin
          if (bus.start) begin
            bus.div_by_zero <= 1'b0;
            if (bus.num2 != {BITS{1'b0}}) begin
              div_r    <= bus.num2;
              quo_r    <= bus.num1;
              rem_r    <= {(BITS+1){1'b0}};
              cnt_r    <= CNT_W'(BITS - 1);
              dz_r     <= 1'b0;
              bus.busy <= 1'b1;
              state_r  <= CALC;
            end else begin
              // Zero divisor skips iteration: all-ones quotient, dividend as remainder.
              quo_r   <= {BITS{1'b1}};
              rem_r   <= {1'b0, bus.num1};
              dz_r    <= 1'b1;
              state_r <= DONE;
            end
          end else begin
            state_r <= IDLE;
          end
        end
        CALC: begin
          rem_r <= rem_next_s;
          quo_r <= quo_next_s;
          if (cnt_r == {CNT_W{1'b0}}) begin
            bus.busy <= 1'b0;
            state_r  <= DONE;
          end else begin
            cnt_r <= cnt_r - CNT_W'(1);
          end
        end
        DONE: begin
          bus.done        <= 1'b1;
          bus.quotient    <= quo_r;
          bus.remainder   <= rem_r[BITS-1:0];
          bus.div_by_zero <= dz_r;
          state_r         <= IDLE;
        end
        default: begin
          bus.busy <= 1'b0;
          state_r  <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_div_seq_ctrl.sv
module tb_div_seq_ctrl;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  div_seq_if #(.BITS(4)) if4 ();
  div_seq_if #(.BITS(8)) if8 ();

  div_seq_ctrl #(.BITS(4)) u_dut4 (.clk(clk), .rst_n(rst_n), .bus(if4));
  div_seq_ctrl #(.BITS(8)) u_dut8 (.clk(clk), .rst_n(rst_n), .bus(if8));

  // Issue one start pulse on the 4-bit DUT; lat = edges after accept until done (-1 on timeout).
  task automatic run4(input logic [3:0] n1, input logic [3:0] n2,
                      output logic [3:0] q, output logic [3:0] r,
                      output logic dz, output int lat);
    @(negedge clk);
    if4.num1 = n1; if4.num2 = n2; if4.start = 1'b1;
    @(posedge clk); #1;
    if4.start = 1'b0;
    lat = -1;
    for (int i = 1; i <= 30; i++) begin
      @(posedge clk); #1;
      if (if4.done === 1'b1) begin
        lat = i;
        break;
      end
    end
    q = if4.quotient; r = if4.remainder; dz = if4.div_by_zero;
  endtask

  task automatic run8(input logic [7:0] n1, input logic [7:0] n2,
                      output logic [7:0] q, output logic [7:0] r,
                      output logic dz, output int lat);
    @(negedge clk);
    if8.num1 = n1; if8.num2 = n2; if8.start = 1'b1;
    @(posedge clk); #1;
    if8.start = 1'b0;
    lat = -1;
    for (int i = 1; i <= 30; i++) begin
      @(posedge clk); #1;
      if (if8.done === 1'b1) begin
        lat = i;
        break;
      end
    end
    q = if8.quotient; r = if8.remainder; dz = if8.div_by_zero;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (if4.busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", if4.busy); end
    checks++; if (if4.done !== 1'b0) begin errors++; $display("FAIL reset_done got=%b exp=0", if4.done); end
    checks++; if (if4.div_by_zero !== 1'b0) begin errors++; $display("FAIL reset_dz got=%b exp=0", if4.div_by_zero); end
    checks++; if (if4.quotient !== 4'd0) begin errors++; $display("FAIL reset_q got=%0d exp=0", if4.quotient); end
    checks++; if (if4.remainder !== 4'd0) begin errors++; $display("FAIL reset_r got=%0d exp=0", if4.remainder); end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_basic();
    logic [3:0] q, r; logic dz; int lat;
    run4(4'd13, 4'd3, q, r, dz, lat);
    checks++; if (lat !== 5) begin errors++; $display("FAIL basic_lat got=%0d exp=5", lat); end
    checks++; if (q !== 4'd4) begin errors++; $display("FAIL basic_q got=%0d exp=4", q); end
    checks++; if (r !== 4'd1) begin errors++; $display("FAIL basic_r got=%0d exp=1", r); end
    checks++; if (dz !== 1'b0) begin errors++; $display("FAIL basic_dz got=%b exp=0", dz); end
    @(posedge clk); #1;
    checks++; if (if4.done !== 1'b0) begin errors++; $display("FAIL basic_done_pulse got=%b exp=0", if4.done); end
  endtask

  task automatic test_boundaries();
    logic [3:0] vec [3][4] = '{'{4'd15, 4'd1, 4'd15, 4'd0},
                               '{4'd2,  4'd7, 4'd0,  4'd2},
                               '{4'd0,  4'd5, 4'd0,  4'd0}};
    logic [3:0] q, r; logic dz; int lat;
    for (int i = 0; i < 3; i++) begin
      run4(vec[i][0], vec[i][1], q, r, dz, lat);
      checks++; if (lat !== 5) begin errors++; $display("FAIL bound_lat %0d/%0d got=%0d exp=5", vec[i][0], vec[i][1], lat); end
      checks++; if (q !== vec[i][2]) begin errors++; $display("FAIL bound_q %0d/%0d got=%0d exp=%0d", vec[i][0], vec[i][1], q, vec[i][2]); end
      checks++; if (r !== vec[i][3]) begin errors++; $display("FAIL bound_r %0d/%0d got=%0d exp=%0d", vec[i][0], vec[i][1], r, vec[i][3]); end
      checks++; if (dz !== 1'b0) begin errors++; $display("FAIL bound_dz %0d/%0d got=%b exp=0", vec[i][0], vec[i][1], dz); end
    end
  endtask

  task automatic test_div_by_zero();
    logic [3:0] q, r; logic dz; int lat;
    run4(4'd5, 4'd0, q, r, dz, lat);
    checks++; if (lat !== 1) begin errors++; $display("FAIL dz_lat got=%0d exp=1", lat); end
    checks++; if (q !== 4'd15) begin errors++; $display("FAIL dz_q got=%0d exp=15", q); end
    checks++; if (r !== 4'd5) begin errors++; $display("FAIL dz_r got=%0d exp=5", r); end
    checks++; if (dz !== 1'b1) begin errors++; $display("FAIL dz_flag got=%b exp=1", dz); end
    repeat (3) @(posedge clk);
    #1;
    checks++; if (if4.div_by_zero !== 1'b1) begin errors++; $display("FAIL dz_hold got=%b exp=1", if4.div_by_zero); end
    checks++; if (if4.quotient !== 4'd15) begin errors++; $display("FAIL dz_q_hold got=%0d exp=15", if4.quotient); end
    run4(4'd6, 4'd2, q, r, dz, lat);
    checks++; if (lat !== 5) begin errors++; $display("FAIL dz_after_lat got=%0d exp=5", lat); end
    checks++; if (q !== 4'd3) begin errors++; $display("FAIL dz_after_q got=%0d exp=3", q); end
    checks++; if (r !== 4'd0) begin errors++; $display("FAIL dz_after_r got=%0d exp=0", r); end
    checks++; if (dz !== 1'b0) begin errors++; $display("FAIL dz_after_flag got=%b exp=0", dz); end
  endtask

  task automatic test_ignore_start();
    int busy_cnt = 0; int done_cnt = 0; int done_at = -1;
    logic [3:0] q = 4'd0; logic [3:0] r = 4'd0;
    @(negedge clk);
    if4.num1 = 4'd13; if4.num2 = 4'd3; if4.start = 1'b1;
    @(posedge clk); #1;
    if4.start = 1'b0;
    if (if4.busy === 1'b1) busy_cnt++;
    @(negedge clk);
    if4.start = 1'b1; if4.num1 = 4'd9;
    for (int i = 1; i <= 10; i++) begin
      @(posedge clk); #1;
      if (if4.busy === 1'b1) busy_cnt++;
      if (if4.done === 1'b1) begin
        done_cnt++; done_at = i; q = if4.quotient; r = if4.remainder;
      end
      if (i == 3) if4.start = 1'b0;
    end
    checks++; if (busy_cnt !== 4) begin errors++; $display("FAIL ign_busy_cycles got=%0d exp=4", busy_cnt); end
    checks++; if (done_cnt !== 1) begin errors++; $display("FAIL ign_done_count got=%0d exp=1", done_cnt); end
    checks++; if (done_at !== 5) begin errors++; $display("FAIL ign_lat got=%0d exp=5", done_at); end
    checks++; if (q !== 4'd4) begin errors++; $display("FAIL ign_q got=%0d exp=4", q); end
    checks++; if (r !== 4'd1) begin errors++; $display("FAIL ign_r got=%0d exp=1", r); end
  endtask

  task automatic test_reset_abort();
    int done_cnt = 0;
    logic [3:0] q, r; logic dz; int lat;
    @(negedge clk);
    if4.num1 = 4'd13; if4.num2 = 4'd3; if4.start = 1'b1;
    @(posedge clk); #1;
    if4.start = 1'b0;
    @(posedge clk); #3;
    rst_n = 1'b0;
    #1;
    checks++; if (if4.busy !== 1'b0) begin errors++; $display("FAIL abort_busy got=%b exp=0", if4.busy); end
    checks++; if (if4.quotient !== 4'd0) begin errors++; $display("FAIL abort_q got=%0d exp=0", if4.quotient); end
    checks++; if (if4.remainder !== 4'd0) begin errors++; $display("FAIL abort_r got=%0d exp=0", if4.remainder); end
    checks++; if (if4.div_by_zero !== 1'b0) begin errors++; $display("FAIL abort_dz got=%b exp=0", if4.div_by_zero); end
    @(posedge clk); #3;
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      if (if4.done === 1'b1) done_cnt++;
    end
    checks++; if (done_cnt !== 0) begin errors++; $display("FAIL abort_no_done got=%0d exp=0", done_cnt); end
    run4(4'd7, 4'd2, q, r, dz, lat);
    checks++; if (lat !== 5) begin errors++; $display("FAIL abort_after_lat got=%0d exp=5", lat); end
    checks++; if (q !== 4'd3) begin errors++; $display("FAIL abort_after_q got=%0d exp=3", q); end
    checks++; if (r !== 4'd1) begin errors++; $display("FAIL abort_after_r got=%0d exp=1", r); end
  endtask

  task automatic test_back_to_back();
    int first = -1; int second = -1;
    logic [3:0] q2 = 4'd0; logic [3:0] r2 = 4'd0;
    @(negedge clk);
    if4.num1 = 4'd6; if4.num2 = 4'd2; if4.start = 1'b1;
    @(posedge clk); #1;
    for (int i = 1; i <= 30; i++) begin
      @(posedge clk); #1;
      if (if4.done === 1'b1) begin
        if (first < 0) begin
          first = i;
        end else begin
          second = i; q2 = if4.quotient; r2 = if4.remainder;
          if4.start = 1'b0;
          break;
        end
      end
    end
    if4.start = 1'b0;
    checks++; if (first !== 5) begin errors++; $display("FAIL b2b_first got=%0d exp=5", first); end
    checks++; if (second !== 11) begin errors++; $display("FAIL b2b_second got=%0d exp=11", second); end
    checks++; if (q2 !== 4'd3) begin errors++; $display("FAIL b2b_q got=%0d exp=3", q2); end
    checks++; if (r2 !== 4'd0) begin errors++; $display("FAIL b2b_r got=%0d exp=0", r2); end
    repeat (8) @(posedge clk);
    #1;
    checks++; if (if4.busy !== 1'b0) begin errors++; $display("FAIL b2b_stop got=%b exp=0", if4.busy); end
  endtask

  task automatic test_wide8();
    logic [7:0] q, r, n1, n2, eq, er; logic dz; int lat, elat; logic edz;
    for (int d = 0; d < 256; d++) begin
      for (int j = 0; j < 5; j++) begin
        n2 = 8'(d);
        case (j)
          0: n1 = 8'd0;
          1: n1 = 8'd1;
          2: n1 = 8'd255;
          3: n1 = 8'(d);
          default: n1 = 8'((d * 37 + 11) % 256);
        endcase
        if (n2 == 8'd0) begin
          eq = 8'd255; er = n1; edz = 1'b1; elat = 1;
        end else begin
          eq = n1 / n2; er = n1 % n2; edz = 1'b0; elat = 9;
        end
        run8(n1, n2, q, r, dz, lat);
        checks++;
        if (q !== eq || r !== er || dz !== edz || lat !== elat) begin
          errors++;
          $display("FAIL w8 %0d/%0d got q=%0d r=%0d dz=%b lat=%0d exp q=%0d r=%0d dz=%b lat=%0d",
                   n1, n2, q, r, dz, lat, eq, er, edz, elat);
        end
      end
    end
  endtask

  initial begin
    if4.start = 1'b0; if4.num1 = 4'd0; if4.num2 = 4'd0;
    if8.start = 1'b0; if8.num1 = 8'd0; if8.num2 = 8'd0;
    test_reset();
    test_basic();
    test_boundaries();
    test_div_by_zero();
    test_ignore_start();
    test_reset_abort();
    test_back_to_back();
    test_wide8();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
